// File: rtl/iomem_arb_pkg.sv
// Shared definitions for the iomem arbiter: FSM state encoding, master index
// constants and the default read data returned on a timed-out transfer.
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } arb_state_e;

  localparam logic MstM0 = 1'b0;
  localparam logic MstM1 = 1'b1;

  localparam logic [31:0] TimeoutRdataDefault = 32'hFFFF_FFFF;

endpackage

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the SoC iomem peripheral port between two
// masters, with a per-transaction timeout so a hung slave cannot stall a master.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   m{0,1}_valid/wstrb/addr/wdata  master requests (wstrb == 0 means read)
//   m{0,1}_ready/rdata          master completion and read data
//   s_valid/wstrb/addr/wdata    request forwarded to the slave
//   s_ready/rdata               slave completion and read data
//   timeout_irq                 one-cycle pulse when a transfer is forced done
module iomem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter logic [31:0] TIMEOUT_RDATA  = TimeoutRdataDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        timeout_irq
);

  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic        sel_m1;
  logic        cur_valid;
  logic        timed_out;
  logic        done;
  logic [31:0] cur_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_grant_q <= MstM1;  // so m0 wins the first tie
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    s_valid      = 1'b0;
    s_wstrb      = '0;
    s_addr       = '0;
    s_wdata      = '0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    timeout_irq  = 1'b0;
    sel_m1       = 1'b0;
    cur_valid    = 1'b0;
    timed_out    = 1'b0;
    done         = 1'b0;
    cur_rdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (m0_valid && (!m1_valid || last_grant_q == MstM1)) begin
          state_d      = StBusy0;
          last_grant_d = MstM0;
          cnt_d        = '0;
        end else if (m1_valid) begin
          state_d      = StBusy1;
          last_grant_d = MstM1;
          cnt_d        = '0;
        end
      end

      StBusy0, StBusy1: begin
        sel_m1    = (state_q == StBusy1);
        cur_valid = sel_m1 ? m1_valid : m0_valid;
        s_wstrb   = sel_m1 ? m1_wstrb : m0_wstrb;
        s_addr    = sel_m1 ? m1_addr  : m0_addr;
        s_wdata   = sel_m1 ? m1_wdata : m0_wdata;

        // A real s_ready in the last allowed cycle beats the timeout.
        timed_out   = cur_valid && !s_ready && (cnt_q == CntLast);
        done        = cur_valid && (s_ready || timed_out);
        s_valid     = cur_valid && !timed_out;
        timeout_irq = timed_out;
        cur_rdata   = timed_out ? TIMEOUT_RDATA : s_rdata;

        if (sel_m1) begin
          m1_ready = done;
          m1_rdata = cur_rdata;
        end else begin
          m0_ready = done;
          m0_rdata = cur_rdata;
        end

        // Master dropping valid mid-transfer aborts silently.
        if (!cur_valid || done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

  localparam int unsigned TO       = 4;
  localparam logic [31:0] TO_RDATA = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        s_valid, s_ready, timeout_irq;
  logic [31:0] s_addr, s_wdata, s_rdata;

  // Master-side stimulus state, indexed by master number.
  logic        mv   [2];
  logic [31:0] ma   [2];
  logic [31:0] mw   [2];
  logic [3:0]  ms   [2];
  int          gap  [2];
  logic        seen [2];

  // Reference model: who owns the port, how long it has waited, who went last.
  int owner = -1;
  int age   = 0;
  int last  = 1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign m0_valid = mv[0];
  assign m0_addr  = ma[0];
  assign m0_wdata = mw[0];
  assign m0_wstrb = ms[0];
  assign m1_valid = mv[1];
  assign m1_addr  = ma[1];
  assign m1_wdata = mw[1];
  assign m1_wstrb = ms[1];

  always #5 clk = ~clk;

  iomem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (8),
    .TIMEOUT_RDATA (TO_RDATA)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_wstrb   (m0_wstrb),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_wstrb   (m1_wstrb),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_wstrb    (s_wstrb),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .timeout_irq(timeout_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus, checking and model update.
  task automatic step(input int rdy_pct, input int viol_pct, input int rst_pct,
                      input bit force_rst);
    logic [31:0] r;
    logic        v, to, e_sv, e_irq;
    logic [31:0] e_sa, e_sw;
    logic [3:0]  e_ss;
    logic        e_r  [2];
    logic [31:0] e_rd [2];
    int          g;

    @(negedge clk);
    cyc++;
    // Masters behave like picorv32: valid drops the cycle after ready.
    for (int i = 0; i < 2; i++) begin
      if (mv[i] && seen[i]) begin
        mv[i]  = 1'b0;
        gap[i] = $urandom_range(0, 3);
      end else if (mv[i] && ($urandom_range(0, 99) < viol_pct)) begin
        mv[i]  = 1'b0;
        gap[i] = $urandom_range(0, 3);
      end else if (!mv[i]) begin
        if (gap[i] == 0) begin
          r      = $urandom();
          mv[i]  = 1'b1;
          ma[i]  = {8'h03, r[23:0]};
          mw[i]  = $urandom();
          ms[i]  = 4'($urandom_range(0, 15));
        end else begin
          gap[i]--;
        end
      end
    end
    s_ready = ($urandom_range(0, 99) < rdy_pct);
    s_rdata = $urandom();
    resetn  = !(force_rst || ($urandom_range(0, 99) < rst_pct));

    #1;
    v = 1'b0; to = 1'b0; e_sv = 1'b0; e_irq = 1'b0;
    e_sa = '0; e_sw = '0; e_ss = '0;
    e_r[0] = 1'b0; e_r[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
    if (owner >= 0) begin
      v           = mv[owner];
      to          = v && !s_ready && (age == int'(TO) - 1);
      e_sv        = v && !to;
      e_sa        = ma[owner];
      e_sw        = mw[owner];
      e_ss        = ms[owner];
      e_r[owner]  = v && (s_ready || to);
      e_rd[owner] = to ? TO_RDATA : s_rdata;
      e_irq       = to;
    end

    check("s_valid",     {31'b0, s_valid},     {31'b0, e_sv});
    check("s_addr",      s_addr,               e_sa);
    check("s_wdata",     s_wdata,              e_sw);
    check("s_wstrb",     {28'b0, s_wstrb},     {28'b0, e_ss});
    check("m0_ready",    {31'b0, m0_ready},    {31'b0, e_r[0]});
    check("m1_ready",    {31'b0, m1_ready},    {31'b0, e_r[1]});
    check("m0_rdata",    m0_rdata,             e_rd[0]);
    check("m1_rdata",    m1_rdata,             e_rd[1]);
    check("timeout_irq", {31'b0, timeout_irq}, {31'b0, e_irq});

    seen[0] = e_r[0];
    seen[1] = e_r[1];

    // Next-cycle model state, applied at the coming posedge.
    if (!resetn) begin
      owner = -1; last = 1; age = 0;
    end else if (owner < 0) begin
      g = -1;
      if (mv[0] && mv[1]) g = 1 - last;
      else if (mv[0])     g = 0;
      else if (mv[1])     g = 1;
      if (g >= 0) begin
        owner = g; last = g; age = 0;
      end
    end else if (!v || s_ready || to) begin
      owner = -1;
    end else begin
      age++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; gap[i] = 0; seen[i] = 1'b0;
    end
    resetn  = 1'b0;
    s_ready = 1'b0;
    s_rdata = '0;
    // Let the DUT register reset before the first comparison.
    @(posedge clk);
    @(posedge clk);
    // Reset held while masters already request: outputs must stay quiet,
    // then the tie on release goes to m0.
    for (int n = 0; n < 3; n++) step(50, 0, 0, 1'b1);
    // Normal traffic.
    for (int n = 0; n < 400; n++) step(40, 0, 0, 1'b0);
    // Hung slave: every transfer times out.
    for (int n = 0; n < 120; n++) step(0, 0, 0, 1'b0);
    // Slow slave so ready often lands on the timeout cycle.
    for (int n = 0; n < 300; n++) step(20, 0, 0, 1'b0);
    // Protocol violations and mid-transfer resets.
    for (int n = 0; n < 600; n++) step(25, 3, 2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
